adsr_vca: RTL and testbench

//  Downstream stage of the FM synthesizer. Applies a gated ADSR amplitude envelope to the 24-bit signed AXIS sample stream.

---
 rtl/adsr_pkg.sv | 19 +
 rtl/adsr_env_gen.sv | 110 +++++++++++
 rtl/adsr_vca.sv | 71 +++++++
 tb/tb_adsr_vca.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adsr_pkg.sv
// Shared types and widths for the ADSR amplitude envelope / VCA stage.
package adsr_pkg;

    localparam int unsigned DWIDTH = 24;
    localparam int unsigned EWIDTH = 16;
    // Full signed product fits in 40 bits: |data| <= 2^23, env < 2^16.
    localparam int unsigned PWIDTH = DWIDTH + EWIDTH;

    localparam logic [EWIDTH-1:0] ENV_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } adsr_state_t;

endpackage

// File: rtl/adsr_env_gen.sv
// ADSR envelope generator: state machine plus envelope register, advanced
// only on the 'tick' strobe (one tick per accepted sample).
// Build option: ADSR_EXP_RELEASE_EN selects exponential release.
module adsr_env_gen
    import adsr_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              gate,
    input  logic [EWIDTH-1:0] attack_rate,
    input  logic [EWIDTH-1:0] decay_rate,
    input  logic [EWIDTH-1:0] sustain_level,
    input  logic [EWIDTH-1:0] release_rate,
    output logic [EWIDTH-1:0] env,
    output adsr_state_t       state
);

    adsr_state_t       state_q, state_d, eff_state;
    logic [EWIDTH-1:0] env_q, env_d;
    logic [EWIDTH-1:0] rel_step;
    logic [EWIDTH:0]   att_sum, dec_diff, rel_diff;

    // State and envelope registers, updated only on a sample tick
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            env_q   <= '0;
        end else if (tick) begin
            state_q <= state_d;
            env_q   <= env_d;
        end
    end

    // Release decrement: linear rate, or env >> shift with a floor of 1
`ifdef ADSR_EXP_RELEASE_EN
    logic [EWIDTH-1:0] rel_shift;
    always_comb begin
        rel_shift = env_q >> release_rate[3:0];
        rel_step  = (rel_shift == '0) ? EWIDTH'(1) : rel_shift;
    end
`else
    always_comb begin
        rel_step = release_rate;
    end
`endif

    // Next state: gate override first, then the effective state's arithmetic
    always_comb begin
        state_d   = state_q;
        env_d     = env_q;
        eff_state = state_q;
        att_sum   = {1'b0, env_q} + {1'b0, attack_rate};
        dec_diff  = {1'b0, env_q} - {1'b0, decay_rate};
        rel_diff  = {1'b0, env_q} - {1'b0, rel_step};

        if (gate && (state_q == IDLE || state_q == RELEASE)) begin
            eff_state = ATTACK;
        end else if (!gate && (state_q == ATTACK || state_q == DECAY ||
                               state_q == SUSTAIN)) begin
            eff_state = RELEASE;
        end
        state_d = eff_state;

        case (eff_state)
            ATTACK: begin
                if (att_sum >= {1'b0, ENV_MAX}) begin
                    env_d   = ENV_MAX;
                    state_d = DECAY;
                end else begin
                    env_d = att_sum[EWIDTH-1:0];
                end
            end
            DECAY: begin
                // Borrow bit set means underflow
                if (dec_diff[EWIDTH] || (dec_diff[EWIDTH-1:0] <= sustain_level)) begin
                    env_d   = sustain_level;
                    state_d = SUSTAIN;
                end else begin
                    env_d = dec_diff[EWIDTH-1:0];
                end
            end
            SUSTAIN: begin
                env_d = sustain_level;
            end
            RELEASE: begin
                if (rel_diff[EWIDTH] || (rel_diff[EWIDTH-1:0] == '0)) begin
                    env_d   = '0;
                    state_d = IDLE;
                end else begin
                    env_d = rel_diff[EWIDTH-1:0];
                end
            end
            IDLE: begin
                env_d = env_q;
            end
            default: begin
                env_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Outputs straight from the registers
    always_comb begin
        env   = env_q;
        state = state_q;
    end

endmodule

// File: rtl/adsr_vca.sv
// ADSR VCA: single register slice on the AXIS sample stream, scaling each
// accepted sample by the pre-update envelope value.
// Build option: ADSR_EXP_RELEASE_EN (exponential release in adsr_env_gen).
module adsr_vca
    import adsr_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DWIDTH-1:0] signal_in_data,
    input  logic              signal_in_valid,
    output logic              signal_in_ready,
    output logic [DWIDTH-1:0] signal_out_data,
    output logic              signal_out_valid,
    input  logic              signal_out_ready,
    input  logic              gate,
    input  logic [EWIDTH-1:0] attack_rate,
    input  logic [EWIDTH-1:0] decay_rate,
    input  logic [EWIDTH-1:0] sustain_level,
    input  logic [EWIDTH-1:0] release_rate,
    output logic [EWIDTH-1:0] env_level,
    output logic              busy
);

    logic [DWIDTH-1:0]        data_q, data_d;
    logic                     valid_q;
    logic                     tick;
    logic [EWIDTH-1:0]        env;
    adsr_state_t              state;
    logic signed [PWIDTH-1:0] product;

    adsr_env_gen u_env_gen (
        .clk           (clk),
        .reset_n       (reset_n),
        .tick          (tick),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .env           (env),
        .state         (state)
    );

    // Handshake, signed sample x unsigned envelope, keep product bits [39:16]
    always_comb begin
        signal_in_ready = reset_n && (!valid_q || signal_out_ready);
        tick            = signal_in_valid && signal_in_ready;
        product         = PWIDTH'($signed(signal_in_data)) *
                          PWIDTH'($signed({1'b0, env}));
        data_d          = DWIDTH'(product >>> EWIDTH);
        busy            = (state != IDLE);
        env_level       = env;
    end

    // Output register slice; holds while valid and not ready
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (tick) begin
            data_q  <= data_d;
            valid_q <= 1'b1;
        end else if (signal_out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign signal_out_data  = data_q;
    assign signal_out_valid = valid_q;

endmodule

// File: tb/tb_adsr_vca.sv
// Testbench for adsr_vca: scenario tasks plus a randomized run, checked
// against a sample-level envelope model and an expected-output queue.
// Honors ADSR_EXP_RELEASE_EN to match the exponential-release build.
module tb_adsr_vca;

    localparam int M_IDLE = 0;
    localparam int M_ATK  = 1;
    localparam int M_DEC  = 2;
    localparam int M_SUS  = 3;
    localparam int M_REL  = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        gate;
    logic [15:0] attack_rate, decay_rate, sustain_level, release_rate;
    logic [15:0] env_level;
    logic        busy;

    int vectors    = 0;
    int miscompares = 0;

    int          m_env;
    int          m_st;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    adsr_vca dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .signal_in_data   (in_data),
        .signal_in_valid  (in_valid),
        .signal_in_ready  (in_ready),
        .signal_out_data  (out_data),
        .signal_out_valid (out_valid),
        .signal_out_ready (out_ready),
        .gate             (gate),
        .attack_rate      (attack_rate),
        .decay_rate       (decay_rate),
        .sustain_level    (sustain_level),
        .release_rate     (release_rate),
        .env_level        (env_level),
        .busy             (busy)
    );

    function automatic logic [23:0] scale(input logic [23:0] d, input int e);
        longint p;
        p = longint'($signed(d)) * longint'(e);
        return 24'(p >>> 16);
    endfunction

    // One envelope step from the behavioural rules
    task automatic model_tick();
        int e;
        e = m_env;
        if (gate && (m_st == M_IDLE || m_st == M_REL))
            m_st = M_ATK;
        else if (!gate && (m_st == M_ATK || m_st == M_DEC || m_st == M_SUS))
            m_st = M_REL;
        case (m_st)
            M_ATK: begin
                e = e + int'(attack_rate);
                if (e >= 65535) begin e = 65535; m_st = M_DEC; end
            end
            M_DEC: begin
                e = e - int'(decay_rate);
                if (e <= int'(sustain_level)) begin e = int'(sustain_level); m_st = M_SUS; end
            end
            M_SUS: e = int'(sustain_level);
            M_REL: begin
`ifdef ADSR_EXP_RELEASE_EN
                int d;
                d = e >> release_rate[3:0];
                if (d < 1) d = 1;
                e = e - d;
`else
                e = e - int'(release_rate);
`endif
                if (e <= 0) begin e = 0; m_st = M_IDLE; end
            end
            default: ;
        endcase
        m_env = e;
    endtask

    // Advance one clock, checking interface outputs against the model
    task automatic run_cycle();
        logic exp_ready;
        @(negedge clk);
        exp_ready = reset_n && (exp_q.size() == 0 || out_ready);
        vectors++;
        if (in_ready !== exp_ready) begin
            miscompares++;
            $display("FAIL in_ready: got %b expected %b t=%0t", in_ready, exp_ready, $time);
        end
        vectors++;
        if (out_valid !== (exp_q.size() != 0)) begin
            miscompares++;
            $display("FAIL out_valid: got %b expected %b t=%0t", out_valid, exp_q.size() != 0, $time);
        end
        vectors++;
        if (env_level !== 16'(m_env)) begin
            miscompares++;
            $display("FAIL env_level: got %h expected %h t=%0t", env_level, 16'(m_env), $time);
        end
        vectors++;
        if (busy !== (m_st != M_IDLE)) begin
            miscompares++;
            $display("FAIL busy: got %b expected %b t=%0t", busy, m_st != M_IDLE, $time);
        end
        if (reset_n) begin
            if (exp_q.size() != 0 && out_ready) begin
                logic [23:0] e;
                e = exp_q.pop_front();
                vectors++;
                if (out_data !== e) begin
                    miscompares++;
                    $display("FAIL out_data: got %h expected %h t=%0t", out_data, e, $time);
                end
            end
            if (in_valid && exp_ready) begin
                exp_q.push_back(scale(in_data, m_env));
                model_tick();
            end
        end
        @(posedge clk);
        #1;
        if (!reset_n) begin
            exp_q.delete();
            m_env = 0;
            m_st  = M_IDLE;
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        in_valid = 1'b1;
        repeat (10) run_cycle();
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || env_level !== 16'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: ready=%b valid=%b env=%h busy=%b expected 0 0 0000 0",
                     in_ready, out_valid, env_level, busy);
        end
        reset_n = 1'b1;
        run_cycle();
    endtask

    task automatic test_attack_decay();
        attack_rate   = 16'h1000;
        decay_rate    = 16'h0800;
        sustain_level = 16'h8000;
        release_rate  = 16'h0400;
        out_ready     = 1'b1;
        in_valid      = 1'b1;
        gate          = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 24'($urandom);
            run_cycle();
        end
        vectors++;
        if (env_level !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL attack_peak: got %h expected ffff", env_level);
        end
        for (int i = 0; i < 16; i++) begin
            in_data = 24'($urandom);
            run_cycle();
        end
        vectors++;
        if (env_level !== 16'h8000 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL sustain_reached: env=%h busy=%b expected 8000 1", env_level, busy);
        end
    endtask

    task automatic test_sustain_mult();
        in_data = 24'h400000;
        run_cycle();
        vectors++;
        if (out_data !== 24'h200000 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mult_pos: got %h valid=%b expected 200000 1", out_data, out_valid);
        end
        in_data = 24'hC00000;
        run_cycle();
        vectors++;
        if (out_data !== 24'hE00000 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mult_neg: got %h valid=%b expected e00000 1", out_data, out_valid);
        end
    endtask

    task automatic test_release();
        int ticks;
        logic [15:0] prev;
        gate  = 1'b0;
        ticks = 0;
`ifdef ADSR_EXP_RELEASE_EN
        release_rate = 16'h0004;
`else
        release_rate = 16'h0400;
`endif
        prev = env_level;
        while (busy && ticks < 2000) begin
            in_data = 24'($urandom);
            run_cycle();
            ticks++;
            vectors++;
            if (!(env_level < prev)) begin
                miscompares++;
                $display("FAIL release_monotonic: got %h after %h", env_level, prev);
            end
            prev = env_level;
        end
`ifndef ADSR_EXP_RELEASE_EN
        vectors++;
        if (ticks != 32) begin
            miscompares++;
            $display("FAIL release_ticks: got %0d expected 32", ticks);
        end
`endif
        vectors++;
        if (env_level !== 16'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL release_end: env=%h busy=%b expected 0000 0", env_level, busy);
        end
    endtask

    task automatic test_stall();
        gate        = 1'b1;
        attack_rate = 16'h1000;
        for (int i = 0; i < 3; i++) begin
            in_data = 24'($urandom);
            run_cycle();
        end
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_data = 24'($urandom);
            run_cycle();
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || exp_q.size() != 1 ||
                out_data !== exp_q[0] || env_level !== 16'(m_env)) begin
                miscompares++;
                $display("FAIL stall_hold: ready=%b valid=%b data=%h env=%h expected 0 1 %h %h",
                         in_ready, out_valid, out_data, env_level,
                         (exp_q.size() != 0) ? exp_q[0] : 24'h0, 16'(m_env));
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 24'($urandom);
            run_cycle();
        end
    endtask

    task automatic test_retrigger();
        int prev;
        attack_rate   = 16'h1000;
        decay_rate    = 16'h0800;
        sustain_level = 16'h8000;
        gate          = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_data = 24'($urandom);
            run_cycle();
        end
        vectors++;
        if (env_level !== 16'h8000) begin
            miscompares++;
            $display("FAIL retrig_sustain: got %h expected 8000", env_level);
        end
        gate = 1'b0;
`ifdef ADSR_EXP_RELEASE_EN
        release_rate = 16'h0002;
        for (int i = 0; i < 200 && m_env > 16'h3000; i++) begin
            in_data = 24'($urandom);
            run_cycle();
        end
`else
        release_rate = 16'h0400;
        for (int i = 0; i < 20; i++) begin
            in_data = 24'($urandom);
            run_cycle();
        end
        vectors++;
        if (env_level !== 16'h3000) begin
            miscompares++;
            $display("FAIL retrig_level: got %h expected 3000", env_level);
        end
`endif
        prev = m_env;
        gate = 1'b1;
        run_cycle();
        vectors++;
        if (env_level !== 16'(prev + 'h1000) || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL retrig_attack: got %h expected %h", env_level, 16'(prev + 'h1000));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            in_data   = 24'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) gate = ~gate;
            if ($urandom_range(0, 99) == 0) begin
                attack_rate   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h3000));
                decay_rate    = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h3000));
                sustain_level = 16'($urandom);
                release_rate  = 16'($urandom_range(1, 16'h2000));
            end
            run_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) run_cycle();
    endtask

    initial begin
        reset_n       = 1'b0;
        in_data       = '0;
        in_valid      = 1'b0;
        out_ready     = 1'b1;
        gate          = 1'b0;
        attack_rate   = '0;
        decay_rate    = '0;
        sustain_level = '0;
        release_rate  = '0;
        m_env         = 0;
        m_st          = M_IDLE;
        @(posedge clk);
        #1;
        test_reset();
        test_attack_decay();
        test_sustain_mult();
        test_release();
        test_stall();
        test_retrigger();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
